// File: rtl/sqrt_arbiter_pkg.sv
// Shared definitions for the sqrt request arbiter: default parameter values and the
// controller state encoding.
package sqrt_arbiter_pkg;

  localparam int unsigned DefaultWidth   = 24;  // operand width
  localparam int unsigned DefaultNumReq  = 4;   // requester count
  localparam int unsigned DefaultTagW    = 4;   // requester tag width
  localparam int unsigned DefaultTimeout = 64;  // max cycles waiting for the sqrt unit

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/sqrt_arbiter_rr.sv
// Round-robin grant: combinational search for the first set request at or above the
// priority pointer, wrapping modulo NUM_REQ.
// Ports:
//   req_i  request vector
//   ptr_i  index of the highest-priority requester
//   gnt_o  one-hot grant, all zero when no request is set
module rr_arbiter
  import sqrt_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefaultNumReq,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one external iterative square-root unit between NUM_REQ requesters.
// One operation is in flight at a time: grant (IDLE) -> start pulse (ISSUE) ->
// wait for result or timeout (WAIT) -> hold response until accepted (RESP).
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   req_valid_i/req_ready_o  per-requester request handshake (zero-cycle grant in IDLE)
//   req_n_i, req_tag_i       packed radicands and tags, requester k in slice k
//   rsp_valid_o/rsp_ready_i  per-requester response handshake, one-hot
//   rsp_q_o, rsp_r_o         shared root / remainder
//   rsp_tag_o, rsp_err_o     tag of owning request, timeout flag
//   sq_start_o, sq_n_o       start pulse and held radicand to the sqrt unit
//   sq_q_i, sq_r_i, sq_valid_i  result and one-cycle strobe from the sqrt unit
//   busy_o                   high outside IDLE
module sqrt_arbiter
  import sqrt_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned NUM_REQ = DefaultNumReq,
  parameter int unsigned TAG_W   = DefaultTagW,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_n_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_q_o,
  output logic [WIDTH-1:0]         rsp_r_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
  output logic                     rsp_err_o,
  output logic                     sq_start_o,
  output logic [WIDTH-1:0]         sq_n_o,
  input  logic [WIDTH-1:0]         sq_q_i,
  input  logic [WIDTH-1:0]         sq_r_i,
  input  logic                     sq_valid_i,
  output logic                     busy_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  n_q, n_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IdxW-1:0]    gnt_idx;
  logic [WIDTH-1:0]   gnt_n;
  logic [TAG_W-1:0]   gnt_tag;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (IdxW)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // Select the granted requester's operand and tag.
  always_comb begin
    gnt_idx = '0;
    gnt_n   = '0;
    gnt_tag = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        gnt_idx = IdxW'(k);
        gnt_n   = req_n_i[k*WIDTH +: WIDTH];
        gnt_tag = req_tag_i[k*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    n_d         = n_q;
    q_d         = q_q;
    r_d         = r_q;
    tag_d       = tag_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    req_ready_o = '0;
    unique case (state_q)
      StIdle: begin
        // Gated by reset so no handshake completes on a cycle the state is being cleared.
        req_ready_o = reset_i ? '0 : gnt;
        if (|req_valid_i) begin
          idx_d   = gnt_idx;
          n_d     = gnt_n;
          tag_d   = gnt_tag;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (sq_valid_i) begin
          q_d     = sq_q_i;
          r_d     = sq_r_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // TIMEOUT-th WAIT cycle without a result strobe.
          q_d     = '0;
          r_d     = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i[idx_q]) begin
          ptr_d   = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + IdxW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == StResp) rsp_valid_o[idx_q] = 1'b1;
  end

  // The sqrt unit re-reads its operand every iteration, so hold it through WAIT.
  assign sq_n_o     = (state_q == StIssue || state_q == StWait) ? n_q : '0;
  assign sq_start_o = (state_q == StIssue);
  assign busy_o     = (state_q != StIdle);
  assign rsp_q_o    = q_q;
  assign rsp_r_o    = r_q;
  assign rsp_tag_o  = tag_q;
  assign rsp_err_o  = err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      q_q     <= q_d;
      r_q     <= r_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 24, operand width; NUM_REQ, 4, requester count; TAG_W, 4, requester tag width; TIMEOUT, 64, max cycles waiting for the sqrt unit.
REQ-002 Ports SHALL be (name direction width meaning):
- clk_i  in  1  single clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester request accept
- req_n_i  in  NUM_REQ*WIDTH  radicands, requester k in slice [k*WIDTH +: WIDTH]
- req_tag_i  in  NUM_REQ*TAG_W  tags, requester k in slice [k*TAG_W +: TAG_W]
- rsp_valid_o  out  NUM_REQ  response valid, one-hot or zero
- rsp_ready_i  in  NUM_REQ  response accept
- rsp_q_o  out  WIDTH  root, shared by all requesters
- rsp_r_o  out  WIDTH  remainder, shared
- rsp_tag_o  out  TAG_W  tag of the owning request
- rsp_err_o  out  1  timeout flag, qualified by rsp_valid_o
- sq_start_o  out  1  start pulse to the iterative sqrt unit
- sq_n_o  out  WIDTH  radicand to the sqrt unit
- sq_q_i  in  WIDTH  root from the sqrt unit
- sq_r_i  in  WIDTH  remainder from the sqrt unit
- sq_valid_i  in  1  one-cycle result strobe from the sqrt unit
- busy_o  out  1  high in every state except IDLE

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-004 IDLE: if any req_valid_i bit is set, the arbiter SHALL grant one requester g and assert req_ready_o[g] in that same cycle (zero-cycle handshake). It SHALL then latch req_n_i slice g, req_tag_i slice g and index g, and go to ISSUE. Otherwise it SHALL stay in IDLE with req_ready_o all zero.
REQ-005 Grant SHALL be round-robin. Priority starts at pointer p and searches upward, modulo NUM_REQ. On completion of a response, p SHALL become g+1, wrapping from NUM_REQ-1 to 0.
REQ-006 At most one req_ready_o bit SHALL be high in any cycle, and only in IDLE.
REQ-007 ISSUE: sq_start_o SHALL be 1 for exactly this one cycle; next state SHALL be WAIT.
REQ-008 sq_n_o SHALL equal the latched radicand from the cycle after grant until the exit from WAIT, because the sqrt unit reads its operand on every iteration. It SHALL be 0 in IDLE.
REQ-009 WAIT: on sq_valid_i=1, the block SHALL latch sq_q_i and sq_r_i into rsp_q_o and rsp_r_o, clear the error flag, and go to RESP.
REQ-010 WAIT: a cycle counter SHALL clear on entry. If it reaches TIMEOUT with no sq_valid_i, the block SHALL go to RESP with rsp_err_o=1 and rsp_q_o=rsp_r_o=0.
REQ-011 RESP: rsp_valid_o[g] SHALL be held high, and rsp_q_o, rsp_r_o, rsp_tag_o, rsp_err_o held stable, until rsp_ready_i[g]=1. On that cycle the block SHALL go to IDLE and update p. rsp_ready_i bits other than g SHALL be ignored.
REQ-012 sq_valid_i outside WAIT SHALL be ignored: no state change, no capture.
REQ-013 A new request SHALL NOT be accepted in the cycle a response completes; the earliest next grant is the following IDLE cycle.
REQ-014 Throughput: one operation in flight at most. Latency from grant to rsp_valid_o = 2 + (sqrt unit start-to-valid latency) cycles.
REQ-015 A requester SHALL NOT see its req_valid_i/req_n_i changes after its grant affect the operation in flight.

Reset
REQ-016 When reset_i=1 at a clock edge, the block SHALL set: state=IDLE, p=0, sq_start_o=0, sq_n_o=0, req_ready_o=0, rsp_valid_o=0, rsp_q_o=0, rsp_r_o=0, rsp_tag_o=0, rsp_err_o=0, busy_o=0, timeout counter=0.
REQ-017 Reset in any state SHALL abort the operation silently with no response. The integrator SHALL reset the sqrt unit in the same cycle.

Structure
REQ-018 The state enum and default parameter values SHALL live in package sqrt_arbiter_pkg.
REQ-019 Round-robin grant logic SHALL be a sub-module rr_arbiter: inputs request vector and pointer, output one-hot grant, purely combinational.
REQ-020 The sqrt unit SHALL be instantiated outside this block; this block SHALL contain no square-root arithmetic.

Verification
REQ-021 The bench SHALL cover these directed scenarios (real sqrt unit, WIDTH=24):
- Single request: requester 2, n=144, tag=5 -> rsp_valid_o=4'b0100, rsp_q_o=12, rsp_tag_o=5, rsp_err_o=0.
- All four requesters hold valid from reset, n=0, 1, 0xFFFFFF, 1000000 -> grants in order 0,1,2,3, q=0, 1, 4095, 1000.
- Requester 1 completes, then requesters 0 and 1 both valid -> requester 0 granted next.
- rsp_ready_i held low 20 cycles -> rsp_valid_o and result data stable, no new req_ready_o, busy_o=1.
- sqrt unit model never strobes valid -> after TIMEOUT=64 WAIT cycles, rsp_valid_o with rsp_err_o=1, q=0.
- reset_i pulsed in WAIT, then a spurious sq_valid_i -> block in IDLE with all outputs 0, spurious strobe ignored, next request served normally.
